// File: rtl/qam16_pkg.sv
// Shared types and constants for the QAM16 frame packer.
//   state_e       : packer state (HUNT searches for sync, PAYLOAD packs bytes)
//   sym_t, byte_t : symbol (4-bit) and byte (8-bit) data types
//   fifo_entry_t  : one buffered output entry, first-of-frame flag above the byte
package qam16_pkg;

  localparam int unsigned SYM_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [0:0] {
    HUNT,
    PAYLOAD
  } state_e;

  typedef struct packed {
    logic  first;
    byte_t data;
  } fifo_entry_t;

  localparam byte_t SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/qam16_byte_fifo.sv
// Small synchronous FIFO holding payload bytes plus their first-of-frame flag.
// The head entry is kept in its own register so the output is never a
// fall-through of the write data.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data (accepted when not full, or full with a pop)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   full, empty : occupancy flags
//   head        : registered head-of-FIFO entry
module qam16_byte_fifo
  import qam16_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_entry_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  fifo_entry_t       head_q, head_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = head_q;

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Head tracks the oldest entry: the incoming word when it becomes the
    // only entry, otherwise the next stored word after a pop.
    if (do_push && (empty || (do_pop && count_q == (AW+1)'(1)))) begin
      head_d = push_data;
    end else if (do_pop && count_q > (AW+1)'(1)) begin
      head_d = mem_q[rd_ptr_q + AW'(1)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/qam16_frame_packer.sv
// Searches the demodulated QAM16 symbol stream for a sync byte at nibble
// granularity, then packs the following symbol pairs into FRAME_LEN payload
// bytes that are buffered and delivered on a valid/ready interface.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   sym_valid   : sym_in carries a new symbol this cycle
//   sym_in      : demodulated symbol, I in [3:2], Q in [1:0]
//   byte_out    : head-of-buffer payload byte
//   byte_first  : byte_out is the first payload byte of its frame
//   byte_valid  : buffer non-empty
//   byte_ready  : downstream takes byte_out this cycle
//   locked      : packer is inside a frame payload
//   overflow    : one-cycle pulse, a completed byte was dropped (buffer full)
module qam16_frame_packer
  import qam16_pkg::*;
#(
  parameter byte_t       SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  sym_t        sym_in,
  output byte_t       byte_out,
  output logic        byte_first,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        locked,
  output logic        overflow
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);

  state_e          state_q, state_d;
  // Only the previous symbol is kept; the 8-bit window is {win_q, sym_in}.
  sym_t            win_q, win_d;
  logic [1:0]      fill_q, fill_d;
  logic [1:0]      fill_inc;
  logic            phase_q, phase_d;   // 0: expecting high nibble
  sym_t            hi_q, hi_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;

  logic            fifo_push;
  fifo_entry_t     fifo_wdata;
  logic            fifo_full, fifo_empty;
  fifo_entry_t     fifo_head;
  logic            pop_fire;

  assign pop_fire = byte_valid && byte_ready;
  assign fill_inc = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;

  always_comb begin
    state_d          = state_q;
    win_d            = win_q;
    fill_d           = fill_q;
    phase_d          = phase_q;
    hi_d             = hi_q;
    cnt_d            = cnt_q;
    fifo_push        = 1'b0;
    fifo_wdata.first = (cnt_q == '0);
    fifo_wdata.data  = {hi_q, sym_in};

    unique case (state_q)
      HUNT: begin
        if (sym_valid) begin
          win_d  = sym_in;
          fill_d = fill_inc;
          if (fill_inc == 2'd2 && {win_q, sym_in} == SYNC_BYTE) begin
            state_d = PAYLOAD;
            phase_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (sym_valid) begin
          if (!phase_q) begin
            hi_d    = sym_in;
            phase_d = 1'b1;
          end else begin
            fifo_push = 1'b1;
            phase_d   = 1'b0;
            // Dropped bytes still advance the count, so frames always end.
            if (cnt_q == CntLast) begin
              state_d = HUNT;
              cnt_d   = '0;
              win_d   = '0;
              fill_d  = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    overflow_d = fifo_push && fifo_full && !pop_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      win_q      <= '0;
      fill_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      fill_q     <= fill_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  qam16_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (pop_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign byte_valid = !fifo_empty;
  assign byte_out   = fifo_head.data;
  assign byte_first = fifo_head.first;
  assign locked     = (state_q == PAYLOAD);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_qam16_frame_packer.sv
// Directed bench for qam16_frame_packer (FRAME_LEN=2, FIFO_DEPTH=4).
// Stimulus pushes the expected {first, byte} of every byte that should be
// delivered; an independent monitor pops and compares on each handshake.
module tb_qam16_frame_packer;

  logic       clk;
  logic       rst;
  logic       sym_valid;
  logic [3:0] sym_in;
  logic [7:0] byte_out;
  logic       byte_first;
  logic       byte_valid;
  logic       byte_ready;
  logic       locked;
  logic       overflow;

  int total;
  int bad;
  int ov_count;
  logic [8:0] exp_q[$];

  qam16_frame_packer #(
    .SYNC_BYTE  (8'hA5),
    .FRAME_LEN  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .sym_in     (sym_in),
    .byte_out   (byte_out),
    .byte_first (byte_first),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .locked     (locked),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one symbol for exactly one clock; returns #1 after that edge.
  task automatic send(input logic [3:0] s);
    sym_valid = 1'b1;
    sym_in    = s;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst && overflow) ov_count++;
    if (!rst && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {23'd0, byte_first, byte_out}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("byte", {23'd0, byte_first, byte_out}, {23'd0, e});
      end
    end
  end

  initial begin
    total = 0; bad = 0; ov_count = 0;
    rst = 1'b1; sym_valid = 1'b0; sym_in = 4'h0; byte_ready = 1'b1;
    idle(2);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_first", byte_first, 0);
    rst = 1'b0;

    // Basic frame
    send(4'hA); check("t1_lock_early", locked, 0);
    send(4'h5); check("t1_locked", locked, 1);
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    send(4'h1); send(4'h2);
    check("t1_byte_latency", byte_valid, 1);
    send(4'h3); send(4'h4);
    check("t1_unlock", locked, 0);
    idle(3);
    check("t1_drained", exp_q.size(), 0);

    // Lone symbol after reset cannot lock; misaligned sync
    rst = 1'b1; idle(1); rst = 1'b0;
    send(4'h5); check("t2_no_lock_fill", locked, 0);
    send(4'h3); send(4'hA); check("t2_no_lock_3a", locked, 0);
    send(4'h5); check("t2_lock_misaligned", locked, 1);
    exp_q.push_back({1'b1, 8'hCD});
    exp_q.push_back({1'b0, 8'hEF});
    send(4'hC); send(4'hD); send(4'hE); send(4'hF);
    check("t2_unlock", locked, 0);

    // Payload containing the sync pattern
    send(4'hA); send(4'h5);
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b0, 8'h77});
    send(4'hA); send(4'h5);
    check("t3_no_relock", locked, 1);
    send(4'h7); send(4'h7);
    check("t3_unlock", locked, 0);
    idle(3);
    check("t3_drained", exp_q.size(), 0);

    // Backpressure and overflow: 6 bytes into 4 entries
    byte_ready = 1'b0;
    ov_count = 0;
    exp_q.push_back({1'b1, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33}); exp_q.push_back({1'b0, 8'h44});
    send(4'hA); send(4'h5); send(4'h1); send(4'h1); send(4'h2); send(4'h2);
    send(4'hA); send(4'h5); send(4'h3); send(4'h3); send(4'h4); send(4'h4);
    send(4'hA); send(4'h5); send(4'h5); send(4'h5);
    check("t4_ovf_pulse1", overflow, 1);
    send(4'h6);
    check("t4_ovf_one_cycle", overflow, 0);
    send(4'h6);
    check("t4_ovf_pulse2", overflow, 1);
    check("t4_frame_ends", locked, 0);
    idle(1);
    check("t4_ovf_count", ov_count, 2);
    byte_ready = 1'b1;
    idle(3);
    check("t4_drain_3", byte_valid, 1);
    idle(1);
    check("t4_drain_4_empty", byte_valid, 0);
    check("t4_drained", exp_q.size(), 0);

    // Full FIFO with pop on the completing cycle
    byte_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33}); exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b1, 8'h56}); exp_q.push_back({1'b0, 8'h78});
    send(4'hA); send(4'h5); send(4'h1); send(4'h1); send(4'h2); send(4'h2);
    send(4'hA); send(4'h5); send(4'h3); send(4'h3); send(4'h4); send(4'h4);
    send(4'hA); send(4'h5); send(4'h5);
    byte_ready = 1'b1;
    send(4'h6);
    check("t5_no_overflow", overflow, 0);
    send(4'h7); send(4'h8);
    idle(8);
    check("t5_drained", exp_q.size(), 0);
    check("t5_ovf_count", ov_count, 2);

    // Reset mid-frame discards buffered and partial data
    byte_ready = 1'b0;
    send(4'hA); send(4'h5); send(4'h1); send(4'h2); send(4'h3);
    check("t6_buffered", byte_valid, 1);
    check("t6_locked_pre", locked, 1);
    rst = 1'b1;
    idle(1);
    check("t6_rst_valid", byte_valid, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_byte_out", byte_out, 0);
    check("t6_rst_first", byte_first, 0);
    check("t6_rst_overflow", overflow, 0);
    rst = 1'b0;
    byte_ready = 1'b1;
    send(4'h2); send(4'h3);
    idle(1);
    check("t6_hunt_locked", locked, 0);
    check("t6_hunt_no_byte", byte_valid, 0);

    idle(3);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
